lfsr_stream_checker: RTL and testbench



---
 rtl/lfsr_stream_checker.sv | 102 ++++++++++
 tb/tb_lfsr_stream_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising receive-side monitor for the 8-bit LFSR word stream
module lfsr_stream_checker #(
    parameter logic [7:0] SEED     = 8'd100,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_num,
    input  logic             resync,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_nx;
    logic [7:0]    exp_q, exp_nx;
    logic [GW-1:0] good, good_nx;
    logic [BW-1:0] bad, bad_nx;
    logic          err_nx;

    function automatic logic [7:0] nxt(input logic [7:0] w);
        return {w[4] ^ w[3] ^ w[2] ^ w[0], w[7:1]};
    endfunction

    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        good_nx  = good;
        bad_nx   = bad;
        err_nx   = 1'b0;
        if (resync) begin
            state_nx = VERIFY;
            exp_nx   = SEED;
            good_nx  = '0;
            bad_nx   = '0;
        end else if (in_valid) begin
            case (state)
                SEARCH: if (in_num != 8'd0) begin
                    state_nx = VERIFY;
                    exp_nx   = nxt(in_num);
                    good_nx  = '0;
                end
                VERIFY: if (in_num == exp_q) begin
                    exp_nx  = nxt(in_num);
                    good_nx = good + GW'(1);
                    if (good_nx == GW'(LOCK_CNT)) begin
                        state_nx = LOCKED;
                        bad_nx   = '0;
                    end
                end else if (in_num != 8'd0) begin
                    exp_nx  = nxt(in_num);
                    good_nx = '0;
                end else begin
                    state_nx = SEARCH;
                    good_nx  = '0;
                end
                LOCKED: if (in_num == exp_q) begin
                    bad_nx = '0;
                    exp_nx = nxt(in_num);
                end else begin
                    // flywheel: a corrupted word must not redirect the prediction
                    err_nx = 1'b1;
                    bad_nx = bad + BW'(1);
                    exp_nx = nxt(exp_q);
                    if (bad_nx == BW'(LOSS_CNT)) begin
                        state_nx = SEARCH;
                        good_nx  = '0;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            exp_q     <= '0;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            exp_q     <= exp_nx;
            good      <= good_nx;
            bad       <= bad_nx;
            locked    <= state_nx == LOCKED;
            err_pulse <= err_nx;
            if (err_nx && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: randomized and directed checks of two checker instances against a behavioural model
module tb_lfsr_stream_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_num = 8'd0;
    logic       resync = 1'b0;
    logic       lk0, ep0, lk1, ep1;
    logic [15:0] ec0;
    logic [3:0]  ec1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_stream_checker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_num(in_num), .resync(resync),
        .locked(lk0), .err_pulse(ep0), .err_cnt(ec0)
    );

    lfsr_stream_checker #(.LOSS_CNT(100), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_num(in_num), .resync(resync),
        .locked(lk1), .err_pulse(ep1), .err_cnt(ec1)
    );

    // model: phase 0 hunting, 1 confirming, 2 locked
    int ph[2], ex[2], g[2], b[2], ec[2];
    bit pl[2], ml[2];
    int loss[2] = '{3, 100};
    int emax[2] = '{65535, 15};

    function automatic int nx(input int w);
        return (w >> 1) | (($countones(w & 'h1D) & 1) << 7);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; ex[k] = 0; g[k] = 0; b[k] = 0; ec[k] = 0; pl[k] = 0; ml[k] = 0;
        end
    endtask

    task automatic model_step(input bit v, input int w, input bit rs);
        for (int k = 0; k < 2; k++) begin
            pl[k] = 0;
            if (rs) begin
                ph[k] = 1; ex[k] = 100; g[k] = 0; b[k] = 0;
            end else if (v) begin
                if (ph[k] == 0) begin
                    if (w != 0) begin ph[k] = 1; ex[k] = nx(w); g[k] = 0; end
                end else if (ph[k] == 1) begin
                    if (w == ex[k]) begin
                        g[k]++; ex[k] = nx(w);
                        if (g[k] == 4) begin ph[k] = 2; b[k] = 0; end
                    end else if (w != 0) begin
                        ex[k] = nx(w); g[k] = 0;
                    end else begin
                        ph[k] = 0; g[k] = 0;
                    end
                end else begin
                    if (w == ex[k]) begin
                        b[k] = 0; ex[k] = nx(w);
                    end else begin
                        pl[k] = 1;
                        if (ec[k] < emax[k]) ec[k]++;
                        b[k]++; ex[k] = nx(ex[k]);
                        if (b[k] == loss[k]) begin ph[k] = 0; g[k] = 0; end
                    end
                end
            end
            ml[k] = ph[k] == 2;
        end
    endtask

    task automatic drive(input bit v, input int w, input bit rs);
        @(negedge clk);
        in_valid = v;
        in_num = 8'(w);
        resync = rs;
        @(posedge clk);
        model_step(v, w, rs);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        in_valid = 1'b0;
        resync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({lk0, ep0, ec0} !== 18'd0) begin
            errors++;
            $display("FAIL reset_main: got lk=%0b ep=%0b cnt=%0d want all 0", lk0, ep0, ec0);
        end
        checks++;
        if ({lk1, ep1, ec1} !== 6'd0) begin
            errors++;
            $display("FAIL reset_sat: got lk=%0b ep=%0b cnt=%0d want all 0", lk1, ep1, ec1);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        int w = 'h64;
        for (int i = 0; i < 5; i++) begin
            drive(1, w, 0);
            checks++;
            if ({lk0, ep0, ec0} !== {ml[0], pl[0], 16'(ec[0])}) begin
                errors++;
                $display("FAIL lock word %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk0, ep0, ec0, ml[0], pl[0], ec[0]);
            end
            w = nx(w);
        end
        checks++;
        if (lk0 !== 1'b1 || ec0 !== 16'd0) begin
            errors++;
            $display("FAIL lock_final: got lk=%0b cnt=%0d want lk=1 cnt=0", lk0, ec0);
        end
    endtask

    task automatic test_single_error();
        drive(1, 0, 0);
        checks++;
        if (ep0 !== 1'b1 || ec0 !== 16'd1 || lk0 !== 1'b1) begin
            errors++;
            $display("FAIL single_err: got lk=%0b ep=%0b cnt=%0d want lk=1 ep=1 cnt=1", lk0, ep0, ec0);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, ex[0], 0);
            checks++;
            if ({lk0, ep0, ec0} !== {ml[0], pl[0], 16'(ec[0])}) begin
                errors++;
                $display("FAIL single_err_follow %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk0, ep0, ec0, ml[0], pl[0], ec[0]);
            end
        end
    endtask

    task automatic test_loss_relock();
        int w;
        int base = ec[0];
        for (int i = 0; i < 3; i++) begin
            drive(1, ex[0] ^ $urandom_range(1, 255), 0);
            checks++;
            if ({lk0, ep0, ec0} !== {ml[0], pl[0], 16'(ec[0])}) begin
                errors++;
                $display("FAIL loss %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk0, ep0, ec0, ml[0], pl[0], ec[0]);
            end
        end
        checks++;
        if (lk0 !== 1'b0 || ec0 !== 16'(base + 3)) begin
            errors++;
            $display("FAIL loss_final: got lk=%0b cnt=%0d want lk=0 cnt=%0d", lk0, ec0, base + 3);
        end
        w = $urandom_range(1, 255);
        for (int i = 0; i < 5; i++) begin
            drive(1, w, 0);
            checks++;
            if ({lk0, ep0, ec0} !== {ml[0], pl[0], 16'(ec[0])}) begin
                errors++;
                $display("FAIL relock %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk0, ep0, ec0, ml[0], pl[0], ec[0]);
            end
            w = nx(w);
        end
        checks++;
        if (lk0 !== 1'b1) begin
            errors++;
            $display("FAIL relock_final: got lk=%0b want lk=1", lk0);
        end
    endtask

    task automatic test_resync();
        int w = 'h64;
        int base = ec[0];
        drive(1, $urandom_range(0, 255), 1);
        checks++;
        if (lk0 !== 1'b0 || ep0 !== 1'b0 || ec0 !== 16'(base)) begin
            errors++;
            $display("FAIL resync_drop: got lk=%0b ep=%0b cnt=%0d want lk=0 ep=0 cnt=%0d", lk0, ep0, ec0, base);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, w, 0);
            checks++;
            if ({lk0, ep0, ec0} !== {ml[0], pl[0], 16'(ec[0])}) begin
                errors++;
                $display("FAIL resync word %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk0, ep0, ec0, ml[0], pl[0], ec[0]);
            end
            w = nx(w);
        end
        checks++;
        if (lk0 !== 1'b1) begin
            errors++;
            $display("FAIL resync_lock: got lk=%0b want lk=1", lk0);
        end
    endtask

    task automatic test_zero_words();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0);
            checks++;
            if ({lk0, ep0, ec0} !== 18'd0) begin
                errors++;
                $display("FAIL zero %0d: got lk=%0b ep=%0b cnt=%0d want all 0", i, lk0, ep0, ec0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v = $urandom_range(0, 3) != 0;
            bit rs = $urandom_range(0, 39) == 0;
            int w = ($urandom_range(0, 9) < 8) ? ex[0] : $urandom_range(0, 255);
            drive(v, w, rs);
            checks++;
            if ({lk0, ep0, ec0, lk1, ep1, ec1} !==
                {ml[0], pl[0], 16'(ec[0]), ml[1], pl[1], 4'(ec[1])}) begin
                errors++;
                $display("FAIL random %0d: got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                         i, lk0, ep0, ec0, lk1, ep1, ec1, ml[0], pl[0], ec[0], ml[1], pl[1], ec[1]);
            end
        end
    endtask

    task automatic test_saturate();
        int w = 'h64;
        do_reset();
        drive(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, w, 0);
            w = nx(w);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, ex[1] ^ $urandom_range(1, 255), 0);
            checks++;
            if ({lk1, ep1, ec1} !== {ml[1], pl[1], 4'(ec[1])}) begin
                errors++;
                $display("FAIL sat %0d: got lk=%0b ep=%0b cnt=%0d want lk=%0b ep=%0b cnt=%0d",
                         i, lk1, ep1, ec1, ml[1], pl[1], ec[1]);
            end
        end
        checks++;
        if (ec1 !== 4'hF || lk1 !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got lk=%0b cnt=%0d want lk=1 cnt=15", lk1, ec1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_num = 8'(ex[1] ^ 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({lk0, ep0, ec0, lk1, ep1, ec1} !== 24'd0) begin
            errors++;
            $display("FAIL async_rst: got %0b/%0b/%0d %0b/%0b/%0d want all 0", lk0, ep0, ec0, lk1, ep1, ec1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_resync();
        test_random();
        test_zero_words();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
